// File: rtl/gauss_pkg.sv
// Shared Q-format widths, constants and the Q1.31 -> Q1.15 rounding helper
// for the Box-Muller datapath.
package gauss_pkg;

    localparam int PROD_W          = 32;
    localparam int SAMP_W          = 16;
    localparam int MUL_LAT_DEFAULT = 5;

    localparam logic [SAMP_W-1:0] Q15_MAX = 16'h7FFF;
    localparam logic [SAMP_W-1:0] Q15_MIN = 16'h8000;

    // Round half up; only the positive side can overflow past Q15_MAX.
    function automatic logic [SAMP_W-1:0] round_sat_q31_to_q15(input logic [PROD_W-1:0] p);
        if (p[PROD_W-1 -: SAMP_W+1] == 17'h0FFFF)
            return Q15_MAX;
        if (p == 32'h8000_0000)
            return Q15_MIN;
        return p[PROD_W-1 -: SAMP_W] + {{(SAMP_W-1){1'b0}}, p[PROD_W-SAMP_W-1]};
    endfunction

endpackage

// File: rtl/gauss_sync_fifo.sv
// Synchronous FIFO with a registered head word; out data holds its last
// value while empty.
module gauss_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [LVL_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic             pop_ok;
    logic             push_ok;

    assign rd_next = rd_ptr + 1'b1;
    assign pop_ok  = pop && (level != '0);
    assign push_ok = push && ((level != LVL_W'(DEPTH)) || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            head_data <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_next;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // Head register tracks whatever will sit at rd_ptr after this edge.
            if (pop_ok && (level > LVL_W'(1)))
                head_data <= mem[rd_next];
            else if (push_ok && ((level == '0) || (pop_ok && (level == LVL_W'(1)))))
                head_data <= push_data;
        end
    end

endmodule

// File: rtl/product_round_buffer.sv
// Multiplier back end: tags live multiplier cycles, rounds Q1.31 products to
// Q1.15 and buffers them behind a credit-based in_ready.
module product_round_buffer
    import gauss_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int DEPTH   = 8,
    parameter int LVL_W   = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] prod_in,
    output logic [SAMP_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  fifo_level,
    output logic              overflow,
    input  logic              clear_ovf
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);
    localparam int SUM_W = LVL_W + CNT_W;

    logic [MUL_LAT-1:0] vld_pipe;
    logic [CNT_W-1:0]   inflight;
    logic [SUM_W-1:0]   credit_sum;
    logic               accept;
    logic               drop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MUL_LAT; i++)
            inflight = inflight + CNT_W'(vld_pipe[i]);
    end

    // Depends only on registered state, so op_valid/out_ready never feed in_ready.
    assign credit_sum = SUM_W'(fifo_level) + SUM_W'(inflight);
    assign in_ready   = credit_sum < SUM_W'(DEPTH);
    assign accept     = op_valid && in_ready;
    assign drop       = op_valid && !in_ready;
    assign out_valid  = (fifo_level != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            overflow <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[MUL_LAT-2:0], accept};
            if (drop)
                overflow <= 1'b1;
            else if (clear_ovf)
                overflow <= 1'b0;
        end
    end

    gauss_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMP_W),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (vld_pipe[MUL_LAT-1]),
        .push_data (round_sat_q31_to_q15(prod_in)),
        .pop       (out_valid && out_ready),
        .head_data (out_data),
        .level     (fifo_level)
    );

    a_credit_holds: assert property (@(posedge clk) disable iff (reset)
        !((fifo_level == LVL_W'(DEPTH)) && (inflight != '0)));

endmodule
